// File: rtl/pci_arb_pkg.sv
// pci_arb_pkg: shared definitions for the PCI bus arbiter.
//   - arb_state_t            : arbiter FSM states (IDLE/GRANT/BUSY/TURN)
//   - DEFAULT_GRANT_TIMEOUT  : default number of cycles a grant may go unused
//   - idx_width()            : bit width needed to index n values (minimum 1)
package pci_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BUSY  = 2'd2,
        TURN  = 2'd3
    } arb_state_t;

    localparam int DEFAULT_GRANT_TIMEOUT = 16;

    // Width of a counter/index covering 0..n-1; never narrower than one bit
    // so that degenerate parameter values still give legal vectors.
    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pci_arb_rr_pick.sv
// pci_arb_rr_pick: combinational rotating-priority encoder.
// Finds the first asserted request searching upward from last+1 and
// wrapping modulo NREQ, so the most recent winner has lowest priority.
// Ports:
//   req  [NREQ-1:0]          in   request vector, active-high
//   last [$clog2(NREQ)-1:0]  in   index of the previous winner
//   pick [$clog2(NREQ)-1:0]  out  index of the selected requester
//   any                      out  at least one request is asserted
module pci_arb_rr_pick
    import pci_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]          req,
    input  logic [$clog2(NREQ)-1:0]  last,
    output logic [$clog2(NREQ)-1:0]  pick,
    output logic                     any
);

    localparam int IW = $clog2(NREQ);

    // cand[gi] is the master sitting gi+1 places after last (mod NREQ);
    // cand_req[gi] is its request, i.e. the request vector rotated so that
    // bit 0 is the highest-priority candidate.
    logic [IW-1:0]   cand [NREQ];
    logic [NREQ-1:0] cand_req;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
        logic [IW:0] sum;
        // last < NREQ and gi+1 <= NREQ, so one conditional subtract wraps it.
        assign sum          = {1'b0, last} + (IW+1)'(gi + 1);
        assign cand[gi]     = (sum >= (IW+1)'(NREQ)) ? IW'(sum - (IW+1)'(NREQ))
                                                     : sum[IW-1:0];
        assign cand_req[gi] = req[cand[gi]];
    end

    // Scan from lowest priority to highest so the nearest requester wins.
    always_comb begin
        pick = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (cand_req[i]) begin
                pick = cand[i];
            end
        end
    end

    assign any = |cand_req;

endmodule

// File: rtl/pci_arbiter.sv
// pci_arbiter: central round-robin PCI bus arbiter.
// All inputs are registered once before the FSM sees them, and every output
// comes straight from a flop, so a request sampled at edge N shows up on
// GNT_n after edge N+1 and no input reaches an output combinationally.
// Optional feature macro: PCI_ARB_PARK_EN (bus parking on the last owner).
// Ports:
//   PCI_CLK      in   bus clock, rising-edge
//   RESET_n      in   asynchronous active-low reset
//   REQ_n        in   per-master request, active-low
//   FRAME_n      in   bus FRAME#
//   IRDY_n       in   bus IRDY#
//   GNT_n        out  per-master grant, active-low, at most one low
//   OWNER        out  index of current/last bus owner
//   OWNER_VALID  out  high while a transaction is in progress
//   PROT_ERR     out  one-cycle pulse on FRAME# start with no grant out
module pci_arbiter
    import pci_arb_pkg::*;
#(
    parameter int NREQ          = 4,
    parameter int GRANT_TIMEOUT = DEFAULT_GRANT_TIMEOUT
) (
    input  logic                     PCI_CLK,
    input  logic                     RESET_n,
    input  logic [NREQ-1:0]          REQ_n,
    input  logic                     FRAME_n,
    input  logic                     IRDY_n,
    output logic [NREQ-1:0]          GNT_n,
    output logic [$clog2(NREQ)-1:0]  OWNER,
    output logic                     OWNER_VALID,
    output logic                     PROT_ERR
);

    localparam int IW = $clog2(NREQ);
    localparam int TW = idx_width(GRANT_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(GRANT_TIMEOUT);
    // Timer value seen on the last allowed grant cycle; the revoke happens
    // on that edge so the grant is visible for exactly GRANT_TIMEOUT cycles.
    localparam logic [TW-1:0] TMO_LAST = TW'((GRANT_TIMEOUT == 0) ? 0 : GRANT_TIMEOUT - 1);
    localparam logic [NREQ-1:0] ONE    = {{(NREQ-1){1'b0}}, 1'b1};

    // Sampled inputs
    logic [NREQ-1:0] req_reg;
    logic            frame_reg, irdy_reg, prev_idle_reg;

    arb_state_t      state_reg, state_next;
    logic [NREQ-1:0] gnt_n_reg, gnt_n_next;
    logic [IW-1:0]   last_reg, last_next;
    logic [IW-1:0]   owner_reg, owner_next;
    logic [TW-1:0]   timer_reg, timer_next;
    logic            prot_err_reg, prot_err_next;
    logic            do_grant;

`ifdef PCI_ARB_PARK_EN
    // Park target is tracked separately from last so that it can start at
    // master 0 after reset while last starts at NREQ-1.
    logic [IW-1:0]   park_reg, park_next;
    logic [NREQ-1:0] park_mask;
    logic            parked;
`endif

    logic [IW-1:0]   pick_idx;
    logic            pick_any;
    logic [NREQ-1:0] last_mask;
    logic            bus_idle, frame_start, others_req, timeout;

    pci_arb_rr_pick #(.NREQ(NREQ)) u_pick (
        .req  (req_reg),
        .last (last_reg),
        .pick (pick_idx),
        .any  (pick_any)
    );

    assign last_mask   = ONE << last_reg;
    assign bus_idle    = frame_reg & irdy_reg;
    // FRAME# start = idle on the previous sample, FRAME# low on this one.
    assign frame_start = prev_idle_reg & ~frame_reg;
    assign others_req  = |(req_reg & ~last_mask);
    assign timeout     = (GRANT_TIMEOUT != 0) && (timer_reg == TMO_LAST);

    always_comb begin
        state_next    = state_reg;
        gnt_n_next    = gnt_n_reg;
        last_next     = last_reg;
        owner_next    = owner_reg;
        timer_next    = timer_reg;
        prot_err_next = 1'b0;
        do_grant      = 1'b0;
`ifdef PCI_ARB_PARK_EN
        park_next     = park_reg;
        park_mask     = ONE << park_reg;
        parked        = (gnt_n_reg != '1);
`endif

        case (state_reg)
            IDLE: begin
                if (frame_start && (gnt_n_reg == '1)) begin
                    prot_err_next = 1'b1;
                end
`ifdef PCI_ARB_PARK_EN
                if (parked && frame_start) begin
                    // Parked master owns the bus without having asked.
                    state_next = BUSY;
                    owner_next = park_reg;
                    last_next  = park_reg;
                end else if (parked && |(req_reg & ~park_mask)) begin
                    // Someone else wants the bus: drop the park grant first.
                    gnt_n_next = '1;
                    state_next = TURN;
                end else if (pick_any) begin
                    do_grant = 1'b1;
                end else begin
                    gnt_n_next = ~park_mask;
                end
`else
                do_grant = pick_any;
`endif
                if (do_grant) begin
                    gnt_n_next = ~(ONE << pick_idx);
                    last_next  = pick_idx;
                    timer_next = '0;
                    state_next = GRANT;
`ifdef PCI_ARB_PARK_EN
                    park_next  = pick_idx;
`endif
                end
            end

            GRANT: begin
                if (timer_reg != TMO_MAX) begin
                    timer_next = timer_reg + 1'b1;
                end
                if (timeout) begin
                    gnt_n_next = '1;
                    state_next = TURN;
                end else if (frame_start) begin
                    state_next = BUSY;
                    owner_next = last_reg;
                    if (!req_reg[last_reg] || others_req) begin
                        gnt_n_next = '1;
                    end
                end else if (!req_reg[last_reg]) begin
                    gnt_n_next = '1;
                    state_next = TURN;
                end
            end

            BUSY: begin
                if (bus_idle) begin
                    gnt_n_next = '1;
                    state_next = TURN;
                end else if (!req_reg[last_reg] || others_req) begin
                    // Removing GNT# lets the owner's latency timer end the burst.
                    gnt_n_next = '1;
                end
            end

            TURN: begin
                gnt_n_next = '1;
                state_next = IDLE;
            end

            default: begin
                gnt_n_next = '1;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge PCI_CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            req_reg       <= '0;
            frame_reg     <= 1'b1;
            irdy_reg      <= 1'b1;
            prev_idle_reg <= 1'b1;
            state_reg     <= IDLE;
            gnt_n_reg     <= '1;
            last_reg      <= IW'(NREQ - 1);
            owner_reg     <= '0;
            timer_reg     <= '0;
            prot_err_reg  <= 1'b0;
`ifdef PCI_ARB_PARK_EN
            park_reg      <= '0;
`endif
        end else begin
            req_reg       <= ~REQ_n;
            frame_reg     <= FRAME_n;
            irdy_reg      <= IRDY_n;
            prev_idle_reg <= frame_reg & irdy_reg;
            state_reg     <= state_next;
            gnt_n_reg     <= gnt_n_next;
            last_reg      <= last_next;
            owner_reg     <= owner_next;
            timer_reg     <= timer_next;
            prot_err_reg  <= prot_err_next;
`ifdef PCI_ARB_PARK_EN
            park_reg      <= park_next;
`endif
        end
    end

    assign GNT_n       = gnt_n_reg;
    assign OWNER       = owner_reg;
    assign OWNER_VALID = (state_reg == BUSY);
    assign PROT_ERR    = prot_err_reg;

endmodule

// File: tb/tb_pci_arbiter.sv
// tb_pci_arbiter: directed self-checking bench for pci_arbiter (NREQ=4,
// GRANT_TIMEOUT=16). Inputs change and outputs are sampled 1 ns after the
// rising edge. The parking scenario is compiled when PCI_ARB_PARK_EN is set,
// the unsolicited-FRAME# error scenario otherwise.
module tb_pci_arbiter;

    logic       PCI_CLK = 1'b0;
    logic       RESET_n = 1'b0;
    logic [3:0] REQ_n   = 4'hF;
    logic       FRAME_n = 1'b1;
    logic       IRDY_n  = 1'b1;
    logic [3:0] GNT_n;
    logic [1:0] OWNER;
    logic       OWNER_VALID;
    logic       PROT_ERR;

    int total = 0;
    int bad   = 0;

    pci_arbiter #(.NREQ(4), .GRANT_TIMEOUT(16)) dut (
        .PCI_CLK     (PCI_CLK),
        .RESET_n     (RESET_n),
        .REQ_n       (REQ_n),
        .FRAME_n     (FRAME_n),
        .IRDY_n      (IRDY_n),
        .GNT_n       (GNT_n),
        .OWNER       (OWNER),
        .OWNER_VALID (OWNER_VALID),
        .PROT_ERR    (PROT_ERR)
    );

    always #5 PCI_CLK = ~PCI_CLK;

    task automatic step;
        @(posedge PCI_CLK);
        #1;
    endtask

    task automatic apply_reset;
        RESET_n = 1'b0;
        REQ_n   = 4'hF;
        FRAME_n = 1'b1;
        IRDY_n  = 1'b1;
        step;
        step;
        RESET_n = 1'b1;
    endtask

    task automatic test_reset;
        step;
        total++; if (GNT_n !== 4'hF) begin bad++; $display("FAIL reset_gnt: got %h want f", GNT_n); end
        total++; if (OWNER_VALID !== 1'b0) begin bad++; $display("FAIL reset_ov: got %b want 0", OWNER_VALID); end
        total++; if (PROT_ERR !== 1'b0) begin bad++; $display("FAIL reset_perr: got %b want 0", PROT_ERR); end
        total++; if (OWNER !== 2'd0) begin bad++; $display("FAIL reset_owner: got %0d want 0", OWNER); end
        RESET_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step;
`ifndef PCI_ARB_PARK_EN
            total++; if (GNT_n !== 4'hF) begin bad++; $display("FAIL idle_gnt: got %h want f", GNT_n); end
`endif
        end
        $display("[reset] done");
    endtask

    task automatic test_single;
        apply_reset;
        REQ_n = 4'b1110;
        step;
        total++; if (GNT_n !== 4'hF) begin bad++; $display("FAIL single_lat1: got %h want f", GNT_n); end
        step;
        total++; if (GNT_n !== 4'b1110) begin bad++; $display("FAIL single_gnt: got %h want e", GNT_n); end
        FRAME_n = 1'b0;
        IRDY_n  = 1'b0;
        step;
        step;
        total++; if (OWNER_VALID !== 1'b1) begin bad++; $display("FAIL single_ov: got %b want 1", OWNER_VALID); end
        total++; if (OWNER !== 2'd0) begin bad++; $display("FAIL single_owner: got %0d want 0", OWNER); end
        total++; if (GNT_n !== 4'b1110) begin bad++; $display("FAIL single_busy_gnt: got %h want e", GNT_n); end
        REQ_n   = 4'hF;
        FRAME_n = 1'b1;
        IRDY_n  = 1'b1;
        step;
        total++; if (OWNER_VALID !== 1'b1) begin bad++; $display("FAIL single_ov_hold: got %b want 1", OWNER_VALID); end
        step;
        total++; if (GNT_n !== 4'hF) begin bad++; $display("FAIL single_turn_gnt: got %h want f", GNT_n); end
        total++; if (OWNER_VALID !== 1'b0) begin bad++; $display("FAIL single_turn_ov: got %b want 0", OWNER_VALID); end
        $display("[single] master 0 transaction complete");
    endtask

    task automatic test_release;
        apply_reset;
        REQ_n = 4'b0111;
        step;
        step;
        total++; if (GNT_n !== 4'b0111) begin bad++; $display("FAIL release_gnt: got %h want 7", GNT_n); end
        REQ_n = 4'hF;
        step;
        total++; if (GNT_n !== 4'b0111) begin bad++; $display("FAIL release_hold: got %h want 7", GNT_n); end
        step;
        total++; if (GNT_n !== 4'hF) begin bad++; $display("FAIL release_turn: got %h want f", GNT_n); end
        total++; if (OWNER_VALID !== 1'b0) begin bad++; $display("FAIL release_ov: got %b want 0", OWNER_VALID); end
        $display("[release] master 3 released before FRAME#");
    endtask

    task automatic test_fairness;
        int exp_order [5];
        int n_grants;
        int frame_cnt;
        int idx;
        logic [3:0] prev_gnt;
        exp_order = '{0, 1, 2, 3, 0};
        apply_reset;
        REQ_n     = 4'b0000;
        prev_gnt  = 4'hF;
        n_grants  = 0;
        frame_cnt = 0;
        for (int cyc = 0; cyc < 200 && n_grants < 5; cyc++) begin
            step;
            total++; if ($countones(~GNT_n) > 1) begin bad++; $display("FAIL fair_onehot: got %h want at most one low", GNT_n); end
            total++; if (prev_gnt != 4'hF && GNT_n != 4'hF && GNT_n != prev_gnt) begin
                bad++; $display("FAIL fair_gap: got %h after %h want an all-high cycle", GNT_n, prev_gnt);
            end
            if (frame_cnt > 0) begin
                frame_cnt--;
                if (frame_cnt == 0) begin
                    FRAME_n = 1'b1;
                    IRDY_n  = 1'b1;
                end
            end
            if (GNT_n != 4'hF && prev_gnt == 4'hF) begin
                idx = 0;
                for (int i = 0; i < 4; i++) if (!GNT_n[i]) idx = i;
                total++; if (idx != exp_order[n_grants]) begin
                    bad++; $display("FAIL fair_order%0d: got %0d want %0d", n_grants, idx, exp_order[n_grants]);
                end
                $display("[fair] grant %0d -> master %0d", n_grants, idx);
                n_grants++;
                FRAME_n   = 1'b0;
                IRDY_n    = 1'b0;
                frame_cnt = 3;
            end
            prev_gnt = GNT_n;
        end
        total++; if (n_grants != 5) begin bad++; $display("FAIL fair_count: got %0d want 5", n_grants); end
        REQ_n   = 4'hF;
        FRAME_n = 1'b1;
        IRDY_n  = 1'b1;
    endtask

    task automatic test_timeout;
        int n_low;
        int n_high;
        apply_reset;
        REQ_n = 4'b1001;
        step;
        step;
        total++; if (GNT_n !== 4'b1101) begin bad++; $display("FAIL tmo_gnt1: got %h want d", GNT_n); end
        n_low = 1;
        for (int i = 0; i < 40; i++) begin
            step;
            if (GNT_n !== 4'b1101) break;
            n_low++;
        end
        total++; if (n_low != 16) begin bad++; $display("FAIL tmo_len: got %0d want 16", n_low); end
        n_high = 0;
        for (int i = 0; i < 10; i++) begin
            if (GNT_n !== 4'hF) break;
            n_high++;
            step;
        end
        total++; if (n_high != 2) begin bad++; $display("FAIL tmo_gap: got %0d want 2", n_high); end
        total++; if (GNT_n !== 4'b1011) begin bad++; $display("FAIL tmo_next: got %h want b", GNT_n); end
        $display("[timeout] master 1 revoked after %0d cycles, master 2 granted", n_low);
        REQ_n = 4'hF;
    endtask

    task automatic test_async_reset;
        apply_reset;
        REQ_n = 4'b1011;
        step;
        step;
        FRAME_n = 1'b0;
        IRDY_n  = 1'b0;
        step;
        step;
        total++; if (OWNER_VALID !== 1'b1) begin bad++; $display("FAIL arst_pre_ov: got %b want 1", OWNER_VALID); end
        total++; if (OWNER !== 2'd2) begin bad++; $display("FAIL arst_pre_owner: got %0d want 2", OWNER); end
        total++; if (GNT_n !== 4'b1011) begin bad++; $display("FAIL arst_pre_gnt: got %h want b", GNT_n); end
        #3 RESET_n = 1'b0;
        #1;
        total++; if (GNT_n !== 4'hF) begin bad++; $display("FAIL arst_gnt: got %h want f", GNT_n); end
        total++; if (OWNER_VALID !== 1'b0) begin bad++; $display("FAIL arst_ov: got %b want 0", OWNER_VALID); end
        total++; if (OWNER !== 2'd0) begin bad++; $display("FAIL arst_owner: got %0d want 0", OWNER); end
        $display("[async_reset] reset taken mid-transaction");
        REQ_n   = 4'hF;
        FRAME_n = 1'b1;
        IRDY_n  = 1'b1;
        step;
        RESET_n = 1'b1;
    endtask

`ifdef PCI_ARB_PARK_EN
    task automatic test_park;
        int waited;
        apply_reset;
        step;
        total++; if (GNT_n !== 4'b1110) begin bad++; $display("FAIL park_reset: got %h want e", GNT_n); end
        REQ_n  = 4'b1011;
        waited = 0;
        while (GNT_n !== 4'b1011 && waited < 20) begin
            step;
            waited++;
        end
        total++; if (GNT_n !== 4'b1011) begin bad++; $display("FAIL park_grant2: got %h want b", GNT_n); end
        FRAME_n = 1'b0;
        IRDY_n  = 1'b0;
        step;
        step;
        step;
        REQ_n   = 4'hF;
        FRAME_n = 1'b1;
        IRDY_n  = 1'b1;
        step;
        step;
        for (int i = 0; i < 3; i++) begin
            step;
            total++; if (GNT_n !== 4'b1011) begin bad++; $display("FAIL park_hold%0d: got %h want b", i, GNT_n); end
        end
        FRAME_n = 1'b0;
        step;
        total++; if (PROT_ERR !== 1'b0) begin bad++; $display("FAIL park_perr0: got %b want 0", PROT_ERR); end
        step;
        total++; if (OWNER_VALID !== 1'b1) begin bad++; $display("FAIL park_ov: got %b want 1", OWNER_VALID); end
        total++; if (OWNER !== 2'd2) begin bad++; $display("FAIL park_owner: got %0d want 2", OWNER); end
        total++; if (PROT_ERR !== 1'b0) begin bad++; $display("FAIL park_perr1: got %b want 0", PROT_ERR); end
        step;
        total++; if (PROT_ERR !== 1'b0) begin bad++; $display("FAIL park_perr2: got %b want 0", PROT_ERR); end
        $display("[park] parked master 2 started FRAME# without REQ#");
        FRAME_n = 1'b1;
    endtask
`else
    task automatic test_prot_err;
        apply_reset;
        FRAME_n = 1'b0;
        step;
        total++; if (PROT_ERR !== 1'b0) begin bad++; $display("FAIL perr_early: got %b want 0", PROT_ERR); end
        step;
        total++; if (PROT_ERR !== 1'b1) begin bad++; $display("FAIL perr_pulse: got %b want 1", PROT_ERR); end
        total++; if (GNT_n !== 4'hF) begin bad++; $display("FAIL perr_gnt: got %h want f", GNT_n); end
        step;
        total++; if (PROT_ERR !== 1'b0) begin bad++; $display("FAIL perr_end: got %b want 0", PROT_ERR); end
        total++; if (OWNER_VALID !== 1'b0) begin bad++; $display("FAIL perr_ov: got %b want 0", OWNER_VALID); end
        $display("[prot_err] unsolicited FRAME# flagged");
        FRAME_n = 1'b1;
    endtask
`endif

    initial begin
        test_reset;
        test_single;
        test_release;
        test_fairness;
        test_timeout;
        test_async_reset;
`ifdef PCI_ARB_PARK_EN
        test_park;
`else
        test_prot_err;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
